// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: registered fetch address, stall/branch/halt control, one instruction per cycle.
// Defining IFU_PERF_CNT_EN enables the saturating fetch_count performance counter; otherwise it reads 0.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = `INSTMEM_ADDR_WIDTH,
  parameter int                    INST_WIDTH  = `INST_LENGTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  inst_valid,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cap_pc_q, cap_pc_d;
  logic                  cap_valid_q, cap_valid_d;
  logic [INST_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] cap_data;

  // While stalled the memory keeps re-reading imem_addr, so the word for cap_pc is parked in the skid register.
  assign cap_data = skid_valid_q ? skid_q : imem_data;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cap_pc_d     = cap_pc_q;
    cap_valid_d  = cap_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: begin
        state_d     = RUN;
        cap_pc_d    = addr_q;
        cap_valid_d = 1'b0;
      end
      RUN: begin
        if (branch_en) begin
          addr_d       = branch_target;
          cap_valid_d  = 1'b0;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
        end else if (stall) begin
          if (!skid_valid_q) begin
            skid_d       = imem_data;
            skid_valid_d = 1'b1;
          end
        end else begin
          addr_d       = addr_q + 1'b1;
          cap_pc_d     = addr_q;
          cap_valid_d  = 1'b1;
          inst_d       = cap_data;
          pc_d         = cap_pc_q;
          valid_d      = cap_valid_q;
          skid_valid_d = 1'b0;
          if (cap_valid_q && (cap_data[INST_WIDTH-1 -: 4] == HALT_OPCODE)) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (!stall) begin
          valid_d     = 1'b0;
          cap_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= RESET_PC;
      cap_pc_q     <= '0;
      cap_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      inst_q       <= '0;
      pc_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cap_pc_q     <= cap_pc_d;
      cap_valid_q  <= cap_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_addr  = addr_q;
  assign inst_out   = inst_q;
  assign pc_out     = pc_q;
  assign inst_valid = valid_q;
  assign halted     = (state_q == HALT);

`ifdef IFU_PERF_CNT_EN
  logic        fetch_pulse;
  logic [15:0] count_q;

  assign fetch_pulse = (state_q == RUN) && !branch_en && !stall && cap_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (fetch_pulse && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: program-order model plus directed stall/branch/halt/reset vectors.
// RESET_PC sits two below the top of the address space so the reset sequence exercises address wrap.
module tb_instruction_fetch_unit;

  localparam int              AW  = 8;
  localparam int              IW  = 32;
  localparam logic [AW-1:0]   RPC = 8'hFE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data = '0;
  logic          stall = 1'b0;
  logic          branch_en = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [IW-1:0] inst_out;
  logic [AW-1:0] pc_out;
  logic          inst_valid;
  logic          halted;
  logic [15:0]   fetch_count;

  logic [IW-1:0] mem [256];

  // Model: where fetch is, which program-order address comes out next, and how many clean edges until it does.
  logic [AW-1:0] mAddr, mNext, mPc;
  logic [IW-1:0] mInst;
  logic          mValid, mHalted, mIdle;
  int            mWarm, mCount;

  int  passCount = 0;
  int  checkCount = 0;
  bit  checkEn = 1'b0;
  bit  reached;

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .RESET_PC   (RPC),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    mAddr   = RPC;
    mNext   = RPC;
    mPc     = '0;
    mInst   = '0;
    mValid  = 1'b0;
    mHalted = 1'b0;
    mIdle   = 1'b1;
    mWarm   = 2;
    mCount  = 0;
  endtask

  task automatic modelStep();
    if (mHalted) begin
      if (!stall) mValid = 1'b0;
    end else if (mIdle) begin
      mIdle = 1'b0;
    end else if (branch_en) begin
      mValid = 1'b0;
      mAddr  = branch_target;
      mNext  = branch_target;
      mWarm  = 2;
    end else if (!stall) begin
      mAddr = mAddr + 8'd1;
      if (mWarm > 1) begin
        mWarm--;
      end else begin
        mWarm  = 0;
        mPc    = mNext;
        mInst  = mem[mNext];
        mValid = 1'b1;
        mNext  = mNext + 8'd1;
        if (mCount < 65535) mCount++;
        if (mInst[31:28] == 4'hF) mHalted = 1'b1;
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Every falling edge the DUT is held against the model; pc/inst only matter while valid.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("inst_valid", inst_valid, mValid);
        checkOutput("imem_addr", imem_addr, mAddr);
        checkOutput("halted", halted, mHalted);
`ifdef IFU_PERF_CNT_EN
        checkOutput("fetch_count", fetch_count, mCount);
`else
        checkOutput("fetch_count", fetch_count, 32'd0);
`endif
        if (mValid) begin
          checkOutput("pc_out", pc_out, mPc);
          checkOutput("inst_out", inst_out, mInst);
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic b, input logic [AW-1:0] t, input int n);
    stall         = s;
    branch_en     = b;
    branch_target = t;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitForPc(input logic [AW-1:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!ok) begin
        if (mValid && (mPc == pc)) ok = 1'b1;
        else @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h00A5_0000 | i;
    mem[7] = 32'hF0A5_0007;

    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_addr", imem_addr, 32'hFE);
    checkOutput("rst_valid", inst_valid, 32'd0);
    checkOutput("rst_halted", halted, 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);

    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("first_valid", inst_valid, 32'd1);
    checkOutput("first_pc", pc_out, 32'hFE);
    checkOutput("first_inst", inst_out, 32'h00A5_00FE);
    checkOutput("first_addr", imem_addr, 32'h00);

    waitForPc(8'h01, reached);
    checkOutput("reach_pc01", reached, 32'd1);
`ifdef IFU_PERF_CNT_EN
    checkOutput("count_four", fetch_count, 32'd4);
`else
    checkOutput("count_off", fetch_count, 32'd0);
`endif

    waitForPc(8'h03, reached);
    checkOutput("reach_pc03", reached, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h20, 1);
    checkOutput("br_valid", inst_valid, 32'd0);
    checkOutput("br_addr", imem_addr, 32'h20);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("br_bubble", inst_valid, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("br_tgt_valid", inst_valid, 32'd1);
    checkOutput("br_tgt_pc", pc_out, 32'h20);
    checkOutput("br_tgt_inst", inst_out, 32'h00A5_0020);

    applyStimulus(1'b1, 1'b1, 8'h04, 1);
    checkOutput("bs_addr", imem_addr, 32'h04);
    checkOutput("bs_valid", inst_valid, 32'd0);

    applyStimulus(1'b0, 1'b0, 8'h00, 0);
    waitForPc(8'h05, reached);
    checkOutput("reach_pc05", reached, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 3);
    checkOutput("st_pc", pc_out, 32'h05);
    checkOutput("st_inst", inst_out, 32'h00A5_0005);
    checkOutput("st_addr", imem_addr, 32'h07);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("st_next_pc", pc_out, 32'h06);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("halt_pc", pc_out, 32'h07);
    checkOutput("halt_inst", inst_out, 32'hF0A5_0007);
    checkOutput("halt_flag", halted, 32'd1);
`ifdef IFU_PERF_CNT_EN
    checkOutput("halt_count", fetch_count, 32'd11);
`endif

    applyStimulus(1'b1, 1'b0, 8'h00, 2);
    checkOutput("halt_stall_valid", inst_valid, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h40, 3);
    checkOutput("halt_br_addr", imem_addr, 32'h09);
    checkOutput("halt_br_valid", inst_valid, 32'd0);
    checkOutput("halt_br_halted", halted, 32'd1);

    applyStimulus(1'b0, 1'b0, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rh_halted", halted, 32'd0);
    checkOutput("rh_addr", imem_addr, 32'hFE);
    checkOutput("rh_valid", inst_valid, 32'd0);
    checkOutput("rh_pc", pc_out, 32'd0);
    checkOutput("rh_inst", inst_out, 32'd0);
    checkOutput("rh_count", fetch_count, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    waitForPc(8'h02, reached);
    checkOutput("reach_pc02", reached, 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 3);
    checkOutput("mr_valid", inst_valid, 32'd1);
    checkOutput("mr_pc", pc_out, 32'hFE);
    applyStimulus(1'b0, 1'b0, 8'h00, 4);
    checkOutput("mr_run_pc", pc_out, 32'h02);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
